// File: rtl/compare_tree_sched.sv
// Multi-pass scheduler feeding one shared compare_tree (min) and folding per-block results into
// a global minimum. Optional early-exit threshold is enabled by defining CMP_SCHED_THRESH_EN.
module compare_tree_sched #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BLOCKS = 16,
    parameter int unsigned BLK_W      = $clog2(MAX_BLOCKS + 1),
    parameter int unsigned IDX_W      = $clog2(MAX_BLOCKS) + DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [BLK_W-1:0]                  num_blocks_i,
    output logic                              busy_o,
    input  logic                              blk_valid_i,
    output logic                              blk_ready_o,
    input  logic [(1<<DEPTH)*DATA_WIDTH-1:0]  blk_data_i,
    output logic [(1<<DEPTH)*DATA_WIDTH-1:0]  tree_val_o,
    output logic [(1<<DEPTH)*IDX_W-1:0]       tree_user_o,
    output logic                              tree_vld_o,
    input  logic [DATA_WIDTH-1:0]             tree_val_i,
    input  logic [IDX_W-1:0]                  tree_user_i,
    input  logic                              tree_vld_i,
`ifdef CMP_SCHED_THRESH_EN
    input  logic [DATA_WIDTH-1:0]             thresh_i,
    output logic                              early_o,
`endif
    output logic                              done_o,
    output logic                              empty_o,
    output logic [DATA_WIDTH-1:0]             res_val_o,
    output logic [IDX_W-1:0]                  res_idx_o
);

    localparam int unsigned L = 1 << DEPTH;
    localparam logic [BLK_W-1:0] MaxBlk = BLK_W'(MAX_BLOCKS);
    localparam logic signed [DATA_WIDTH-1:0] ValMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                       state_q, state_d;
    logic [BLK_W-1:0]             n_q, n_d;
    logic [BLK_W-1:0]             issue_cnt_q, issue_cnt_d;
    logic [BLK_W-1:0]             ret_cnt_q, ret_cnt_d;
    logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]             best_idx_q, best_idx_d;
    logic                         best_vld_q, best_vld_d;
    logic [L*DATA_WIDTH-1:0]      tree_val_q, tree_val_d;
    logic [L*IDX_W-1:0]           tree_user_q, tree_user_d;
    logic                         tree_vld_q, tree_vld_d;
    logic                         done_q, done_d;
    logic                         empty_q, empty_d;
    logic [DATA_WIDTH-1:0]        res_val_q, res_val_d;
    logic [IDX_W-1:0]             res_idx_q, res_idx_d;

    logic             thresh_hit;
    logic             issue_ok;
    logic             hs;
    logic             ret;
    logic [BLK_W-1:0] n_clamp;

`ifdef CMP_SCHED_THRESH_EN
    logic signed [DATA_WIDTH-1:0] thresh_q;
    logic                         early_q;

    // Stop issuing once the running minimum is already good enough.
    assign thresh_hit = best_vld_q && (best_val_q <= thresh_q);
    assign early_o    = early_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q <= '0;
            early_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && start_i) begin
                thresh_q <= $signed(thresh_i);
            end
            if (state_q == StDone) begin
                early_q <= (issue_cnt_q < n_q);
            end
        end
    end
`else
    assign thresh_hit = 1'b0;
`endif

    assign n_clamp     = (num_blocks_i > MaxBlk) ? MaxBlk : num_blocks_i;
    assign issue_ok    = (state_q == StIssue) && (issue_cnt_q < n_q) && !thresh_hit;
    assign hs          = issue_ok && blk_valid_i;
    // Returns landing in IDLE are leftovers from an aborted search.
    assign ret         = (state_q != StIdle) && tree_vld_i;

    assign busy_o      = (state_q != StIdle);
    assign blk_ready_o = issue_ok;
    assign tree_val_o  = tree_val_q;
    assign tree_user_o = tree_user_q;
    assign tree_vld_o  = tree_vld_q;
    assign done_o      = done_q;
    assign empty_o     = empty_q;
    assign res_val_o   = res_val_q;
    assign res_idx_o   = res_idx_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        best_vld_d  = best_vld_q;
        tree_val_d  = tree_val_q;
        tree_user_d = tree_user_q;
        tree_vld_d  = 1'b0;
        done_d      = 1'b0;
        empty_d     = empty_q;
        res_val_d   = res_val_q;
        res_idx_d   = res_idx_q;

        if (ret) begin
            ret_cnt_d = ret_cnt_q + BLK_W'(1);
            // Strict compare: on a cross-block tie the earlier block keeps the win.
            if (!best_vld_q || ($signed(tree_val_i) < best_val_q)) begin
                best_val_d = $signed(tree_val_i);
                best_idx_d = tree_user_i;
                best_vld_d = 1'b1;
            end
        end

        if (hs) begin
            tree_val_d  = blk_data_i;
            tree_vld_d  = 1'b1;
            issue_cnt_d = issue_cnt_q + BLK_W'(1);
            for (int k = 0; k < L; k++) begin
                tree_user_d[k*IDX_W +: IDX_W] = (IDX_W'(issue_cnt_q) << DEPTH) | IDX_W'(k);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    n_d         = n_clamp;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    best_val_d  = ValMax;
                    best_idx_d  = '0;
                    best_vld_d  = 1'b0;
                    state_d     = (n_clamp == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (issue_cnt_d == n_q || thresh_hit) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (ret_cnt_d == issue_cnt_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d    = 1'b1;
                empty_d   = (n_q == '0);
                res_val_d = best_val_q;
                res_idx_d = best_idx_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            best_val_q  <= ValMax;
            best_idx_q  <= '0;
            best_vld_q  <= 1'b0;
            tree_val_q  <= '0;
            tree_user_q <= '0;
            tree_vld_q  <= 1'b0;
            done_q      <= 1'b0;
            empty_q     <= 1'b0;
            res_val_q   <= '0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            best_vld_q  <= best_vld_d;
            tree_val_q  <= tree_val_d;
            tree_user_q <= tree_user_d;
            tree_vld_q  <= tree_vld_d;
            done_q      <= done_d;
            empty_q     <= empty_d;
            res_val_q   <= res_val_d;
            res_idx_q   <= res_idx_d;
        end
    end

endmodule

// File: tb/tb_compare_tree_sched.sv
// Scoreboard bench for compare_tree_sched with a behavioural compare_tree (min) in the loop.
module tb_compare_tree_sched;

    localparam int DEPTH = 2;
    localparam int DW    = 16;
    localparam int MB    = 8;
    localparam int L     = 4;
    localparam int BLK_W = 4;
    localparam int IDX_W = 5;
    localparam int T     = 2 * DEPTH + 1;

    typedef struct {
        int val;
        int idx;
        bit empty;
        bit early;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [BLK_W-1:0]    num_blocks;
    logic                busy;
    logic                blk_valid;
    logic                blk_ready;
    logic [L*DW-1:0]     blk_data;
    logic [L*DW-1:0]     tree_val_o;
    logic [L*IDX_W-1:0]  tree_user_o;
    logic                tree_vld_o;
    logic [DW-1:0]       tree_val_i;
    logic [IDX_W-1:0]    tree_user_i;
    logic                tree_vld_i;
    logic                done;
    logic                empty;
    logic [DW-1:0]       res_val;
    logic [IDX_W-1:0]    res_idx;
`ifdef CMP_SCHED_THRESH_EN
    logic [DW-1:0]       thresh;
    logic                early;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int vld_cnt  = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    exp_t sb_q[$];
    logic [L*DW-1:0] blk_mem [MB];

    compare_tree_sched #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .MAX_BLOCKS (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .num_blocks_i (num_blocks),
        .busy_o       (busy),
        .blk_valid_i  (blk_valid),
        .blk_ready_o  (blk_ready),
        .blk_data_i   (blk_data),
        .tree_val_o   (tree_val_o),
        .tree_user_o  (tree_user_o),
        .tree_vld_o   (tree_vld_o),
        .tree_val_i   (tree_val_i),
        .tree_user_i  (tree_user_i),
        .tree_vld_i   (tree_vld_i),
`ifdef CMP_SCHED_THRESH_EN
        .thresh_i     (thresh),
        .early_o      (early),
`endif
        .done_o       (done),
        .empty_o      (empty),
        .res_val_o    (res_val),
        .res_idx_o    (res_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running tree model: T-stage pipeline, min with lowest lane winning ties, no reset.
    logic            p_vld [T];
    logic [DW-1:0]   p_val [T];
    logic [IDX_W-1:0] p_idx [T];
    logic [DW-1:0]   m_val;
    logic [IDX_W-1:0] m_idx;

    always_comb begin
        m_val = tree_val_o[DW-1:0];
        m_idx = tree_user_o[IDX_W-1:0];
        for (int k = 1; k < L; k++) begin
            if ($signed(tree_val_o[k*DW +: DW]) < $signed(m_val)) begin
                m_val = tree_val_o[k*DW +: DW];
                m_idx = tree_user_o[k*IDX_W +: IDX_W];
            end
        end
    end

    initial begin
        for (int s = 0; s < T; s++) begin
            p_vld[s] = 1'b0;
            p_val[s] = '0;
            p_idx[s] = '0;
        end
    end

    always @(posedge clk) begin
        for (int s = T - 1; s > 0; s--) begin
            p_vld[s] <= p_vld[s-1];
            p_val[s] <= p_val[s-1];
            p_idx[s] <= p_idx[s-1];
        end
        p_vld[0] <= tree_vld_o;
        p_val[0] <= m_val;
        p_idx[0] <= m_idx;
    end

    assign tree_vld_i  = p_vld[T-1];
    assign tree_val_i  = p_val[T-1];
    assign tree_user_i = p_idx[T-1];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (tree_vld_o) vld_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("empty", int'(empty), int'(e.empty));
                    if (!e.empty) begin
                        check("res_val", int'($signed(res_val)), e.val);
                        check("res_idx", int'(res_idx), e.idx);
                    end
`ifdef CMP_SCHED_THRESH_EN
                    check("early", int'(early), int'(e.early));
`endif
                end
            end
        end
    end

    function automatic logic [L*DW-1:0] mk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic exp_t ref_exp(input int n);
        exp_t e;
        int   v;
        bit   first;
        e.val = 0;
        e.idx = 0;
        e.empty = (n == 0);
        e.early = 1'b0;
        first = 1'b1;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < L; k++) begin
                v = int'($signed(blk_mem[j][k*DW +: DW]));
                if (first || v < e.val) begin
                    e.val = v;
                    e.idx = j * L + k;
                    first = 1'b0;
                end
            end
        end
        return e;
    endfunction

    task automatic start_search(input int n, input exp_t e, input bit push);
        num_blocks = BLK_W'(n);
        if (push) sb_q.push_back(e);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_block(input logic [L*DW-1:0] d);
        bit ok;
        ok = 1'b0;
        blk_data  = d;
        blk_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (blk_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("blk_ready_timeout", 0, 1);
        else @(posedge clk);
        #1;
        blk_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", done_cnt, target);
        #1;
    endtask

    initial begin
        exp_t e;
        int   d0;
        int   v0;

        rst        = 1'b1;
        start      = 1'b0;
        num_blocks = '0;
        blk_valid  = 1'b0;
        blk_data   = '0;
`ifdef CMP_SCHED_THRESH_EN
        thresh     = 16'h8000;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(blk_ready), 0);
        check("rst_tree_vld", int'(tree_vld_o), 0);
        check("rst_tree_val", int'(tree_val_o != '0), 0);
        check("rst_tree_user", int'(tree_user_o != '0), 0);
        check("rst_done", int'(done), 0);
        check("rst_empty", int'(empty), 0);
        check("rst_res_val", int'(res_val), 0);
        check("rst_res_idx", int'(res_idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Three blocks, continuous valid; cross-block tie on -3 keeps block 1.
        blk_mem[0] = mk(5, 9, 7, 6);
        blk_mem[1] = mk(8, -3, 4, 2);
        blk_mem[2] = mk(1, 0, -3, 10);
        d0 = done_cnt;
        v0 = vld_cnt;
        e = ref_exp(3);
        start_search(3, e, 1'b1);
        for (int j = 0; j < 3; j++) send_block(blk_mem[j]);
        wait_done(d0 + 1);
        repeat (3) @(posedge clk);
        #1;
        check("n3_done_count", done_cnt - d0, 1);
        check("n3_vld_count", vld_cnt - v0, 3);
        check("n3_busy_after", int'(busy), 0);

        // Two blocks with a three-cycle valid gap.
        blk_mem[0] = mk(100, 200, 300, 400);
        blk_mem[1] = mk(-32768, 0, 0, 1);
        d0 = done_cnt;
        v0 = vld_cnt;
        e = ref_exp(2);
        start_search(2, e, 1'b1);
        send_block(blk_mem[0]);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("gap_tree_vld", int'(tree_vld_o), 0);
            check("gap_ready", int'(blk_ready), 1);
        end
        send_block(blk_mem[1]);
        wait_done(d0 + 1);
        check("gap_vld_count", vld_cnt - v0, 2);

        // Empty search.
        d0 = done_cnt;
        v0 = vld_cnt;
        e = ref_exp(0);
        start_search(0, e, 1'b1);
        wait_done(d0 + 1);
        check("n0_latency", done_cyc - start_cyc, 2);
        check("n0_vld_count", vld_cnt - v0, 0);

        // Second start during ISSUE must be ignored.
        blk_mem[0] = mk(5, 9, 7, 6);
        blk_mem[1] = mk(8, -3, 4, 2);
        d0 = done_cnt;
        v0 = vld_cnt;
        e = ref_exp(2);
        start_search(2, e, 1'b1);
        send_block(blk_mem[0]);
        start_search(5, e, 1'b0);
        send_block(blk_mem[1]);
        wait_done(d0 + 1);
        repeat (20) @(posedge clk);
        #1;
        check("restart_vld_count", vld_cnt - v0, 2);
        check("restart_done_count", done_cnt - d0, 1);
        check("restart_busy", int'(busy), 0);

        // Reset mid-search; stale returns must not leak into the next search.
        d0 = done_cnt;
        start_search(4, e, 1'b0);
        send_block(mk(-50, -60, -70, -80));
        send_block(mk(-90, -91, -92, -93));
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(blk_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        blk_mem[0] = mk(3, 2, 1, 4);
        e = ref_exp(1);
        start_search(1, e, 1'b1);
        send_block(blk_mem[0]);
        wait_done(d0 + 1);

        // Oversized count clamps to MAX_BLOCKS.
        for (int j = 0; j < MB; j++) begin
            blk_mem[j] = mk(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
                            int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000);
        end
        d0 = done_cnt;
        v0 = vld_cnt;
        e = ref_exp(MB);
        start_search(15, e, 1'b1);
        for (int j = 0; j < MB; j++) send_block(blk_mem[j]);
        check("clamp_ready_low", int'(blk_ready), 0);
        wait_done(d0 + 1);
        check("clamp_vld_count", vld_cnt - v0, MB);

`ifdef CMP_SCHED_THRESH_EN
        // Threshold hit after the first block ends the search early.
        thresh = 16'h0000;
        blk_mem[0] = mk(7, -1, 5, 5);
        d0 = done_cnt;
        v0 = vld_cnt;
        e = ref_exp(1);
        e.early = 1'b1;
        start_search(4, e, 1'b1);
        send_block(blk_mem[0]);
        wait_done(d0 + 1);
        check("thr_issued", vld_cnt - v0, 1);
        thresh = 16'h8000;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
